// File: rtl/frame_diff_motion_stat.sv
// frame_diff_motion_stat
//   Two-stage frame differencer with per-frame motion statistics.
//   S1 registers |frame1 - frame2|. S2 thresholds it into a binary mask and
//   accumulates the changed-pixel count and bounding box for the frame.
//   The statistics are latched to the outputs when the next frame starts.
// Ports
//   clk, rst                  pixel clock, synchronous active-high reset
//   thresh                    difference threshold, captured at frame start
//   frame_vsync, frame_href   input frame/line syncs
//   frame1_data, frame2_data  current / reference gray pixels
//   diff_vsync, diff_href     input syncs delayed by 2 clk
//   diff_data                 mask pixel (MASK_ON or 0)
//   frame_done                1-clk pulse when the statistics outputs update
//   motion_cnt, bbox_*        count and bounding box of the last complete frame
//   motion_valid              motion_cnt >= MIN_PIX with a non-empty box
module frame_diff_motion_stat #(
  parameter int unsigned       DATA_W  = 16,
  parameter int unsigned       H_RES   = 640,
  parameter int unsigned       V_RES   = 480,
  parameter int unsigned       CNT_W   = 20,
  parameter int unsigned       MIN_PIX = 64,
  parameter logic [DATA_W-1:0] MASK_ON = {DATA_W{1'b1}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          thresh,
  input  logic                       frame_vsync,
  input  logic                       frame_href,
  input  logic [DATA_W-1:0]          frame1_data,
  input  logic [DATA_W-1:0]          frame2_data,
  output logic                       diff_vsync,
  output logic                       diff_href,
  output logic [DATA_W-1:0]          diff_data,
  output logic                       frame_done,
  output logic [CNT_W-1:0]           motion_cnt,
  output logic [$clog2(H_RES)-1:0]   bbox_x_min,
  output logic [$clog2(H_RES)-1:0]   bbox_x_max,
  output logic [$clog2(V_RES)-1:0]   bbox_y_min,
  output logic [$clog2(V_RES)-1:0]   bbox_y_max,
  output logic                       motion_valid
);

  localparam int unsigned XO_W = $clog2(H_RES);
  localparam int unsigned YO_W = $clog2(V_RES);
  // Position counters are wide enough that their saturated value lies outside
  // the active area, so overlong lines/frames never alias into the stats.
  localparam int unsigned XC_W = $clog2(H_RES + 1);
  localparam int unsigned YC_W = $clog2(V_RES + 1);
  localparam logic [XC_W-1:0] H_LIM = XC_W'(H_RES);
  localparam logic [YC_W-1:0] V_LIM = YC_W'(V_RES);

  logic              vsync_d1_q, vsync_d1_d;
  logic              href_d1_q, href_d1_d;
  logic [DATA_W-1:0] abs_q, abs_d;
  logic [DATA_W-1:0] thr_q, thr_d;
  logic              diff_vsync_q, diff_vsync_d;
  logic              diff_href_q, diff_href_d;
  logic [DATA_W-1:0] diff_data_q, diff_data_d;
  logic [XC_W-1:0]   x_q, x_d;
  logic [YC_W-1:0]   y_q, y_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XO_W-1:0]   xmin_q, xmin_d, xmax_q, xmax_d;
  logic [YO_W-1:0]   ymin_q, ymin_d, ymax_q, ymax_d;
  logic              empty_q, empty_d;
  logic              first_frame_q, first_frame_d;
  logic              frame_done_q, frame_done_d;
  logic [CNT_W-1:0]  motion_cnt_q, motion_cnt_d;
  logic [XO_W-1:0]   bbox_x_min_q, bbox_x_min_d, bbox_x_max_q, bbox_x_max_d;
  logic [YO_W-1:0]   bbox_y_min_q, bbox_y_min_d, bbox_y_max_q, bbox_y_max_d;
  logic              motion_valid_q, motion_valid_d;

  logic [DATA_W:0]   diff, neg_diff;
  logic              vrise_in, vrise_s2, mark, hit;
  logic [XC_W-1:0]   pix_x;
  logic [YC_W-1:0]   pix_y;
  logic [CNT_W-1:0]  acc_cnt;
  logic              acc_empty;

  always_comb begin
    // S1: exact absolute difference using one extra sign bit.
    diff       = {1'b0, frame1_data} - {1'b0, frame2_data};
    neg_diff   = '0 - diff;
    abs_d      = diff[DATA_W] ? neg_diff[DATA_W-1:0] : diff[DATA_W-1:0];
    vsync_d1_d = frame_vsync;
    href_d1_d  = frame_href;

    // Threshold captured at the input-timing vsync edge; pixels already in S1
    // are compared at that same edge against the old value.
    vrise_in = frame_vsync & ~vsync_d1_q;
    thr_d    = vrise_in ? thresh : thr_q;

    // S2: mask and delayed syncs.
    mark         = href_d1_q && (abs_q >= thr_q);
    diff_data_d  = mark ? MASK_ON : '0;
    diff_vsync_d = vsync_d1_q;
    diff_href_d  = href_d1_q;

    // Frame start seen at S2 timing: the pixel in S2 now belongs to the new
    // frame, everything accumulated so far belongs to the old one.
    vrise_s2 = vsync_d1_q & ~diff_vsync_q;
    pix_x    = vrise_s2 ? '0 : x_q;
    pix_y    = vrise_s2 ? '0 : y_q;

    x_d = '0;
    if (href_d1_q) x_d = (pix_x == '1) ? pix_x : pix_x + 1'b1;
    y_d = pix_y;
    if (!vrise_s2 && !href_d1_q && diff_href_q)
      y_d = (y_q == '1) ? y_q : y_q + 1'b1;

    hit       = mark && (pix_x < H_LIM) && (pix_y < V_LIM);
    acc_cnt   = vrise_s2 ? '0 : cnt_q;
    acc_empty = vrise_s2 ? 1'b1 : empty_q;
    cnt_d     = acc_cnt;
    empty_d   = acc_empty;
    xmin_d    = xmin_q;
    xmax_d    = xmax_q;
    ymin_d    = ymin_q;
    ymax_d    = ymax_q;
    if (hit) begin
      cnt_d   = (acc_cnt == '1) ? acc_cnt : acc_cnt + 1'b1;
      empty_d = 1'b0;
      if (acc_empty) begin
        xmin_d = XO_W'(pix_x);
        xmax_d = XO_W'(pix_x);
        ymin_d = YO_W'(pix_y);
        ymax_d = YO_W'(pix_y);
      end else begin
        if (XO_W'(pix_x) < xmin_q) xmin_d = XO_W'(pix_x);
        if (XO_W'(pix_x) > xmax_q) xmax_d = XO_W'(pix_x);
        if (YO_W'(pix_y) < ymin_q) ymin_d = YO_W'(pix_y);
        if (YO_W'(pix_y) > ymax_q) ymax_d = YO_W'(pix_y);
      end
    end

    // Frame close: publish the old frame's totals.
    first_frame_d  = first_frame_q;
    frame_done_d   = 1'b0;
    motion_cnt_d   = motion_cnt_q;
    bbox_x_min_d   = bbox_x_min_q;
    bbox_x_max_d   = bbox_x_max_q;
    bbox_y_min_d   = bbox_y_min_q;
    bbox_y_max_d   = bbox_y_max_q;
    motion_valid_d = motion_valid_q;
    if (vrise_s2) begin
      first_frame_d = 1'b0;
      if (!first_frame_q) begin
        frame_done_d   = 1'b1;
        motion_cnt_d   = cnt_q;
        bbox_x_min_d   = empty_q ? '0 : xmin_q;
        bbox_x_max_d   = empty_q ? '0 : xmax_q;
        bbox_y_min_d   = empty_q ? '0 : ymin_q;
        bbox_y_max_d   = empty_q ? '0 : ymax_q;
        motion_valid_d = !empty_q && (cnt_q >= CNT_W'(MIN_PIX));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d1_q     <= 1'b0;
      href_d1_q      <= 1'b0;
      abs_q          <= '0;
      thr_q          <= DATA_W'(1);
      diff_vsync_q   <= 1'b0;
      diff_href_q    <= 1'b0;
      diff_data_q    <= '0;
      x_q            <= '0;
      y_q            <= '0;
      cnt_q          <= '0;
      xmin_q         <= '0;
      xmax_q         <= '0;
      ymin_q         <= '0;
      ymax_q         <= '0;
      empty_q        <= 1'b1;
      first_frame_q  <= 1'b1;
      frame_done_q   <= 1'b0;
      motion_cnt_q   <= '0;
      bbox_x_min_q   <= '0;
      bbox_x_max_q   <= '0;
      bbox_y_min_q   <= '0;
      bbox_y_max_q   <= '0;
      motion_valid_q <= 1'b0;
    end else begin
      vsync_d1_q     <= vsync_d1_d;
      href_d1_q      <= href_d1_d;
      abs_q          <= abs_d;
      thr_q          <= thr_d;
      diff_vsync_q   <= diff_vsync_d;
      diff_href_q    <= diff_href_d;
      diff_data_q    <= diff_data_d;
      x_q            <= x_d;
      y_q            <= y_d;
      cnt_q          <= cnt_d;
      xmin_q         <= xmin_d;
      xmax_q         <= xmax_d;
      ymin_q         <= ymin_d;
      ymax_q         <= ymax_d;
      empty_q        <= empty_d;
      first_frame_q  <= first_frame_d;
      frame_done_q   <= frame_done_d;
      motion_cnt_q   <= motion_cnt_d;
      bbox_x_min_q   <= bbox_x_min_d;
      bbox_x_max_q   <= bbox_x_max_d;
      bbox_y_min_q   <= bbox_y_min_d;
      bbox_y_max_q   <= bbox_y_max_d;
      motion_valid_q <= motion_valid_d;
    end
  end

  assign diff_vsync   = diff_vsync_q;
  assign diff_href    = diff_href_q;
  assign diff_data    = diff_data_q;
  assign frame_done   = frame_done_q;
  assign motion_cnt   = motion_cnt_q;
  assign bbox_x_min   = bbox_x_min_q;
  assign bbox_x_max   = bbox_x_max_q;
  assign bbox_y_min   = bbox_y_min_q;
  assign bbox_y_max   = bbox_y_max_q;
  assign motion_valid = motion_valid_q;

endmodule

// File: tb/tb_frame_diff_motion_stat.sv
// tb_frame_diff_motion_stat
//   Scoreboard bench: the driver pushes expected mask pixels and per-frame
//   statistics into queues from a frame-level reference model; a monitor pops
//   and compares whenever the DUT presents a pixel or a frame_done pulse.
module tb_frame_diff_motion_stat;

  localparam int HR = 640;
  localparam int VR = 480;
  localparam int MP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] thresh;
  logic        frame_vsync, frame_href;
  logic [15:0] frame1_data, frame2_data;
  logic        diff_vsync, diff_href, frame_done, motion_valid;
  logic [15:0] diff_data;
  logic [19:0] motion_cnt;
  logic [9:0]  bbox_x_min, bbox_x_max;
  logic [8:0]  bbox_y_min, bbox_y_max;

  frame_diff_motion_stat #(
    .DATA_W (16),
    .H_RES  (HR),
    .V_RES  (VR),
    .CNT_W  (20),
    .MIN_PIX(MP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .thresh      (thresh),
    .frame_vsync (frame_vsync),
    .frame_href  (frame_href),
    .frame1_data (frame1_data),
    .frame2_data (frame2_data),
    .diff_vsync  (diff_vsync),
    .diff_href   (diff_href),
    .diff_data   (diff_data),
    .frame_done  (frame_done),
    .motion_cnt  (motion_cnt),
    .bbox_x_min  (bbox_x_min),
    .bbox_x_max  (bbox_x_max),
    .bbox_y_min  (bbox_y_min),
    .bbox_y_max  (bbox_y_max),
    .motion_valid(motion_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt; int x0; int x1; int y0; int y1; int valid;
  } stat_t;

  logic [15:0] px_q[$];
  stat_t       st_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  // Reference model state (frame-level view)
  int m_thr, m_cnt, m_x0, m_x1, m_y0, m_y1, cur_x, cur_y;
  bit m_first, m_empty;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event not expected at %0t", name, $time);
  endtask

  // Monitor
  logic vs_h1 = 1'b0, vs_h2 = 1'b0;
  always @(negedge clk) begin
    logic [15:0] e;
    stat_t s;
    if (!rst) begin
      chk("diff_vsync_delay", {31'd0, diff_vsync}, {31'd0, vs_h2});
      if (diff_href) begin
        if (px_q.size() == 0) fail_evt("extra_pixel");
        else begin
          e = px_q.pop_front();
          chk("diff_data", {16'd0, diff_data}, {16'd0, e});
        end
      end else begin
        chk("diff_data_idle", {16'd0, diff_data}, 32'd0);
      end
      if (frame_done) begin
        if (st_q.size() == 0) fail_evt("unexpected_frame_done");
        else begin
          s = st_q.pop_front();
          chk("motion_cnt",   {12'd0, motion_cnt},   s.cnt);
          chk("bbox_x_min",   {22'd0, bbox_x_min},   s.x0);
          chk("bbox_x_max",   {22'd0, bbox_x_max},   s.x1);
          chk("bbox_y_min",   {23'd0, bbox_y_min},   s.y0);
          chk("bbox_y_max",   {23'd0, bbox_y_max},   s.y1);
          chk("motion_valid", {31'd0, motion_valid}, s.valid);
        end
      end
    end
    vs_h2 = vs_h1;
    vs_h1 = frame_vsync;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_acc();
    m_cnt = 0; m_empty = 1'b1;
    m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
  endtask

  task automatic put_px(input logic [15:0] a, input logic [15:0] b);
    int d;
    bit m;
    d = int'(a) - int'(b);
    if (d < 0) d = -d;
    m = (d >= m_thr);
    px_q.push_back(m ? 16'hFFFF : 16'h0000);
    if (m && cur_x < HR && cur_y < VR) begin
      if (m_empty) begin
        m_x0 = cur_x; m_x1 = cur_x; m_y0 = cur_y; m_y1 = cur_y;
      end else begin
        if (cur_x < m_x0) m_x0 = cur_x;
        if (cur_x > m_x1) m_x1 = cur_x;
        if (cur_y < m_y0) m_y0 = cur_y;
        if (cur_y > m_y1) m_y1 = cur_y;
      end
      m_empty = 1'b0;
      m_cnt++;
    end
    cur_x++;
    frame_href = 1'b1; frame1_data = a; frame2_data = b;
    tick();
  endtask

  task automatic end_line();
    frame_href = 1'b0;
    frame1_data = 16'($urandom); frame2_data = 16'($urandom);
    tick(); tick();
    cur_x = 0;
    cur_y++;
  endtask

  task automatic frame_start(input int t);
    stat_t s;
    frame_href = 1'b0;
    repeat (3) tick();
    if (!m_first) begin
      s.cnt   = m_cnt;
      s.x0    = m_empty ? 0 : m_x0;
      s.x1    = m_empty ? 0 : m_x1;
      s.y0    = m_empty ? 0 : m_y0;
      s.y1    = m_empty ? 0 : m_y1;
      s.valid = (!m_empty && m_cnt >= MP) ? 1 : 0;
      st_q.push_back(s);
    end
    m_first = 1'b0;
    clear_acc();
    m_thr = t;
    thresh = 16'(t);
    frame_vsync = 1'b1;
    tick();
    frame_vsync = 1'b0;
    repeat (3) tick();
    cur_x = 0; cur_y = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_href = 1'b0; frame_vsync = 1'b0;
    repeat (3) tick();
    px_q.delete();
    st_q.delete();
    m_first = 1'b1; m_thr = 1; clear_acc();
    cur_x = 0; cur_y = 0;
    rst = 1'b0;
    tick();
    chk("rst_motion_cnt",   {12'd0, motion_cnt},   32'd0);
    chk("rst_bbox_x_min",   {22'd0, bbox_x_min},   32'd0);
    chk("rst_bbox_x_max",   {22'd0, bbox_x_max},   32'd0);
    chk("rst_bbox_y_min",   {23'd0, bbox_y_min},   32'd0);
    chk("rst_bbox_y_max",   {23'd0, bbox_y_max},   32'd0);
    chk("rst_motion_valid", {31'd0, motion_valid}, 32'd0);
    chk("rst_frame_done",   {31'd0, frame_done},   32'd0);
    chk("rst_diff_href",    {31'd0, diff_href},    32'd0);
    chk("rst_diff_data",    {16'd0, diff_data},    32'd0);
  endtask

  task automatic rand_line(input int n);
    logic [15:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = 16'($urandom);
      else b = a + 16'($urandom_range(0, 40)) - 16'd20;
      put_px(a, b);
    end
    end_line();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    rst = 1'b1; thresh = '0; frame_vsync = 1'b0; frame_href = 1'b0;
    frame1_data = '0; frame2_data = '0;
    tick();
    do_reset();

    // Equal frames: nothing marked, first vsync gives no frame_done
    frame_start(1);
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 8; i++) put_px(16'h0040, 16'h0040);
      end_line();
    end
    frame_start(16);

    // Threshold boundary and sign handling, then full-scale differences
    put_px(16'h0010, 16'h0000); put_px(16'h0000, 16'h0010);
    put_px(16'h000F, 16'h0000); put_px(16'h0000, 16'h000F);
    put_px(16'hFFFF, 16'h0000); put_px(16'h0000, 16'hFFFF);
    end_line();
    frame_start(0);
    rand_line(8);
    for (int i = 0; i < 4; i++) put_px(16'h1234, 16'h1234);
    end_line();

    // Sparse frame with a known bounding box
    frame_start(1);
    for (int y = 0; y <= 200; y++) begin
      if (y == 3) begin
        for (int x = 0; x <= 100; x++) begin
          r = 16'($urandom);
          if (x == 5 || x == 100) put_px(16'h0080, 16'h0000);
          else put_px(r, r);
        end
      end else if (y == 200) begin
        for (int x = 0; x <= 42; x++) begin
          r = 16'($urandom);
          if (x == 42) put_px(16'h0000, 16'h0080);
          else put_px(r, r);
        end
      end else begin
        r = 16'($urandom);
        put_px(r, r);
      end
      end_line();
    end

    // Mid-frame threshold change only takes effect at the next frame
    frame_start(1);
    for (int i = 0; i < 8; i++) put_px(16'd100, 16'd50);
    end_line();
    thresh = 16'd100;
    for (int i = 0; i < 8; i++) put_px(16'd50, 16'd100);
    end_line();
    frame_start(100);
    for (int i = 0; i < 8; i++) put_px(16'd100, 16'd50);
    put_px(16'd200, 16'd50);
    end_line();

    // Reset mid-frame drops the partial frame
    frame_start(1);
    for (int i = 0; i < 10; i++) put_px(16'h0200, 16'h0000);
    do_reset();
    frame_start(1);
    put_px(16'd7, 16'd7); put_px(16'd7, 16'd7);
    for (int i = 0; i < 3; i++) put_px(16'h0300, 16'h0001);
    put_px(16'd9, 16'd9);
    end_line();
    for (int x = 0; x < 652; x++) begin
      r = 16'($urandom);
      if (x == 650) put_px(16'hF000, 16'h0000);
      else put_px(r, r);
    end
    end_line();

    // Randomized frames
    for (int f = 0; f < 4; f++) begin
      frame_start(int'($urandom_range(0, 40)));
      for (int l = 0; l < int'($urandom_range(1, 4)); l++)
        rand_line(int'($urandom_range(1, 24)));
    end
    frame_start(1);

    repeat (10) tick();
    chk("pending_pixels", px_q.size(), 32'd0);
    chk("pending_frame_done", st_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
